step_sched: RTL and testbench
=============================

STEP_SCHED -- requirements
Module: step_sched

Interface
REQ-001 Parameter NREQ, default 3: number of requesters sharing the phase sequencer.
REQ-002 Parameter CNT_W, default 4: width of each per-requester step count.
REQ-003 Parameter GAP, default 2: minimum idle cycles between consecutive step pulses; 0 is legal.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NREQ  per-requester request level; held high until done or abort.
REQ-007 len  input  NREQ*CNT_W  packed step counts; requester i uses bits [i*CNT_W +: CNT_W].
REQ-008 gnt  output  NREQ  one-hot grant, registered.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 step  output  1  single-cycle advance pulse to the shared 3-phase sequencer.
REQ-011 phase  output  2  mirrored sequencer phase: 00, 01, 10.
REQ-012 done  output  NREQ  single-cycle completion pulse to the granted requester.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN, GAPW and DONE; every output SHALL decode from registers only.
REQ-014 IDLE: with any req high at an edge, the block SHALL select the winner round-robin starting at pointer ptr, latch len[winner] into rem, set gnt one-hot, and enter RUN; with rem latched 0 it SHALL enter DONE instead.
REQ-015 Round-robin: search order ptr, ptr+1, ..., wrapping modulo NREQ; ptr SHALL become (winner+1) mod NREQ on leaving DONE.
REQ-016 RUN lasts one cycle with step=1; at its closing edge rem SHALL decrement, phase SHALL advance 00->01->10->00, and next state SHALL be DONE if rem was 1, GAPW if GAP>0, else RUN.
REQ-017 GAPW SHALL hold step=0 for exactly GAP cycles, then return to RUN.
REQ-018 DONE lasts one cycle with done[winner]=1 and gnt still held; next state SHALL be IDLE with gnt=0.
REQ-019 Latency for len=L: the first step SHALL occur in the cycle after the sampling edge; steps SHALL be spaced GAP+1 cycles apart; done SHALL occur in the cycle after the last step.
REQ-020 Abort: req[winner] low in RUN or GAPW SHALL cause a transition to IDLE at that edge, with no step at that edge, no done, gnt cleared, ptr advanced as in DONE, and phase retained.
REQ-021 Requests arriving outside IDLE SHALL be ignored until the block returns to IDLE; len changes after latching SHALL have no effect.
REQ-022 An illegal phase value 11 SHALL advance to 00 on the next step.
REQ-023 At most one gnt bit and at most one done bit SHALL be high in any cycle; step SHALL never be high outside RUN.

Reset
REQ-024 rst low SHALL immediately force state=IDLE, gnt=0, done=0, step=0, busy=0, phase=00, rem=0, ptr=0, regardless of the clock.
REQ-025 Reset asserted mid-operation SHALL abandon the transfer with no done pulse; operation SHALL resume on the first rising edge after rst goes high.

Verification
REQ-026 GAP=2, req=001, len0=3 sampled at edge 0 -> gnt=001 in cycles 1-8; step in cycles 1,4,7; phase 01,10,00 after each step; done=001 in cycle 8; gnt=000 in cycle 9.
REQ-027 req=111 held with all len=1, ptr=0 -> grants issued in the order 001, 010, 100, 001; each grant produces exactly one step and one done.
REQ-028 len0=0, req=001 -> DONE is entered directly; done=001 is asserted with no step pulse; phase is unchanged.
REQ-029 GAP=0, len=4 -> four consecutive step cycles; phase ends one step past its start (mod 3); done follows in the next cycle.
REQ-030 req0 dropped during GAPW after 2 steps -> IDLE at the next edge; no done; phase=10; ptr=1.
REQ-031 rst pulsed low during RUN, between clock edges -> all outputs zero and phase=00 immediately; a new req afterwards is granted starting from ptr=0.

Source files
------------

// File: rtl/step_sched.sv
// step_sched: round-robin arbiter driving a shared 3-phase step sequencer.
// Ports: clk, rst (async active-low), req/len in, gnt/busy/step/phase/done out.
module step_sched #(
   parameter int NREQ  = 3,
   parameter int CNT_W = 4,
   parameter int GAP   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*CNT_W-1:0] len,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic                  step,
   output logic [1:0]            phase,
   output logic [NREQ-1:0]       done
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [PW-1:0] PLAST = PW'(NREQ - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      GAPW,
      DONE
   } state_t;

   state_t            state, state_n;
   logic [NREQ-1:0]   gnt_n;
   logic [CNT_W-1:0]  rem, rem_n;
   logic [PW-1:0]     ptr, ptr_n;
   logic [PW-1:0]     win, win_n;
   logic [1:0]        phase_n;
   logic [GW-1:0]     gcnt, gcnt_n;

   logic              found;
   logic [PW-1:0]     pick;
   logic [NREQ-1:0]   pick_oh;
   logic [CNT_W-1:0]  pick_len;
   logic [PW-1:0]     ptr_adv;
   logic [1:0]        phase_adv;
   logic              abort;

   // Round-robin search starting at ptr, wrapping modulo NREQ.
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         pick_oh[i] = (PW'(i) == pick);
      end
      pick_len = len[int'(pick)*CNT_W +: CNT_W];
   end

   assign ptr_adv = (win == PLAST) ? '0 : win + PW'(1);
   assign abort   = ((req & gnt) == '0);

   // Illegal phase 11 recovers to 00 on the next step.
   always_comb begin
      phase_adv = 2'b00;
      unique case (1'b1)
         (phase == 2'b00): phase_adv = 2'b01;
         (phase == 2'b01): phase_adv = 2'b10;
         (phase == 2'b10): phase_adv = 2'b00;
         (phase == 2'b11): phase_adv = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         gnt   <= '0;
         rem   <= '0;
         ptr   <= '0;
         win   <= '0;
         phase <= 2'b00;
         gcnt  <= '0;
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         rem   <= rem_n;
         ptr   <= ptr_n;
         win   <= win_n;
         phase <= phase_n;
         gcnt  <= gcnt_n;
      end
   end

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      rem_n   = rem;
      ptr_n   = ptr;
      win_n   = win;
      phase_n = phase;
      gcnt_n  = gcnt;
      unique case (state)
         IDLE: begin
            if (found) begin
               win_n   = pick;
               gnt_n   = pick_oh;
               rem_n   = pick_len;
               state_n = (pick_len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_n = IDLE;
               gnt_n   = '0;
               ptr_n   = ptr_adv;
            end else begin
               rem_n   = rem - CNT_W'(1);
               phase_n = phase_adv;
               gcnt_n  = '0;
               if (rem == CNT_W'(1))
                  state_n = DONE;
               else if (GAP > 0)
                  state_n = GAPW;
               else
                  state_n = RUN;
            end
         end
         GAPW: begin
            if (abort) begin
               state_n = IDLE;
               gnt_n   = '0;
               ptr_n   = ptr_adv;
            end else if (gcnt == GLAST) begin
               state_n = RUN;
            end else begin
               gcnt_n = gcnt + GW'(1);
            end
         end
         DONE: begin
            state_n = IDLE;
            gnt_n   = '0;
            ptr_n   = ptr_adv;
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign step = (state == RUN);
   assign done = (state == DONE) ? gnt : '0;

endmodule

// File: tb/tb_step_sched.sv
// tb_step_sched: directed checks of step_sched, GAP=2 and GAP=0 instances.
// Observed vector per cycle is {gnt, step, done, busy, phase}.
module tb_step_sched;

   logic        clk;
   logic        rst;
   logic [2:0]  req_a, req_b;
   logic [11:0] len_a, len_b;
   logic [2:0]  gnt_a, gnt_b, done_a, done_b;
   logic        busy_a, busy_b, step_a, step_b;
   logic [1:0]  phase_a, phase_b;

   int checks   = 0;
   int failures = 0;

   step_sched #(.NREQ(3), .CNT_W(4), .GAP(2)) dut_a (
      .clk(clk), .rst(rst), .req(req_a), .len(len_a),
      .gnt(gnt_a), .busy(busy_a), .step(step_a),
      .phase(phase_a), .done(done_a)
   );

   step_sched #(.NREQ(3), .CNT_W(4), .GAP(0)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .len(len_b),
      .gnt(gnt_b), .busy(busy_b), .step(step_b),
      .phase(phase_b), .done(done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [9:0] obs_a();
      return {gnt_a, step_a, done_a, busy_a, phase_a};
   endfunction

   function automatic logic [9:0] obs_b();
      return {gnt_b, step_b, done_b, busy_b, phase_b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b0;
      req_a = '0;
      req_b = '0;
      #7;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst   = 1'b0;
      req_a = 3'b111;
      req_b = 3'b111;
      len_a = 12'h111;
      len_b = 12'h111;
      tick();
      checks++;
      if (obs_a() !== 10'b0) begin
         failures++;
         $display("FAIL reset_a got=%b exp=%b", obs_a(), 10'b0);
      end
      checks++;
      if (obs_b() !== 10'b0) begin
         failures++;
         $display("FAIL reset_b got=%b exp=%b", obs_b(), 10'b0);
      end
      req_a = '0;
      req_b = '0;
      #6;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single();
      logic [9:0] e;
      logic [2:0] eg, ed;
      logic       es, eb;
      int         nst;
      nst   = 0;
      req_a = 3'b001;
      len_a = {4'd0, 4'd0, 4'd3};
      for (int c = 1; c <= 9; c++) begin
         tick();
         eg = (c <= 8) ? 3'b001 : 3'b000;
         es = (c == 1 || c == 4 || c == 7);
         ed = (c == 8) ? 3'b001 : 3'b000;
         eb = (c <= 8);
         e  = {eg, es, ed, eb, 2'(nst % 3)};
         checks++;
         if (obs_a() !== e) begin
            failures++;
            $display("FAIL single c=%0d got=%b exp=%b", c, obs_a(), e);
         end
         if (es) nst++;
         if (c == 8) req_a = '0;
      end
   endtask

   task automatic test_rr();
      int         order [4];
      logic [2:0] oh;
      logic [9:0] e;
      order = '{0, 1, 2, 0};
      do_reset();
      req_a = 3'b111;
      len_a = {4'd1, 4'd1, 4'd1};
      for (int g = 0; g < 4; g++) begin
         oh = 3'(1 << order[g]);
         tick();
         e = {oh, 1'b1, 3'b000, 1'b1, 2'(g % 3)};
         checks++;
         if (obs_a() !== e) begin
            failures++;
            $display("FAIL rr_run g=%0d got=%b exp=%b", g, obs_a(), e);
         end
         tick();
         e = {oh, 1'b0, oh, 1'b1, 2'((g + 1) % 3)};
         checks++;
         if (obs_a() !== e) begin
            failures++;
            $display("FAIL rr_done g=%0d got=%b exp=%b", g, obs_a(), e);
         end
         if (g == 3) req_a = '0;
         tick();
         e = {3'b000, 1'b0, 3'b000, 1'b0, 2'((g + 1) % 3)};
         checks++;
         if (obs_a() !== e) begin
            failures++;
            $display("FAIL rr_idle g=%0d got=%b exp=%b", g, obs_a(), e);
         end
      end
   endtask

   task automatic test_zero_len();
      logic [9:0] e;
      req_a = 3'b001;
      len_a = {4'd1, 4'd1, 4'd0};
      tick();
      e = {3'b001, 1'b0, 3'b001, 1'b1, 2'b01};
      checks++;
      if (obs_a() !== e) begin
         failures++;
         $display("FAIL zero_len got=%b exp=%b", obs_a(), e);
      end
      req_a = '0;
      tick();
      e = {3'b000, 1'b0, 3'b000, 1'b0, 2'b01};
      checks++;
      if (obs_a() !== e) begin
         failures++;
         $display("FAIL zero_len_idle got=%b exp=%b", obs_a(), e);
      end
   endtask

   task automatic test_abort();
      logic [9:0] e;
      logic       es;
      int         nst;
      do_reset();
      nst   = 0;
      req_a = 3'b001;
      len_a = {4'd0, 4'd0, 4'd5};
      for (int c = 1; c <= 5; c++) begin
         tick();
         es = (c == 1 || c == 4);
         e  = {3'b001, es, 3'b000, 1'b1, 2'(nst % 3)};
         checks++;
         if (obs_a() !== e) begin
            failures++;
            $display("FAIL abort c=%0d got=%b exp=%b", c, obs_a(), e);
         end
         if (es) nst++;
      end
      req_a = '0;
      tick();
      e = {3'b000, 1'b0, 3'b000, 1'b0, 2'b10};
      checks++;
      if (obs_a() !== e) begin
         failures++;
         $display("FAIL abort_idle got=%b exp=%b", obs_a(), e);
      end
      req_a = 3'b011;
      len_a = 12'h000;
      tick();
      e = {3'b010, 1'b0, 3'b010, 1'b1, 2'b10};
      checks++;
      if (obs_a() !== e) begin
         failures++;
         $display("FAIL abort_ptr got=%b exp=%b", obs_a(), e);
      end
      req_a = '0;
      tick();
   endtask

   task automatic test_ignore();
      logic [9:0] tv [8];
      tv = '{
         {3'b001, 1'b1, 3'b000, 1'b1, 2'b10},
         {3'b001, 1'b0, 3'b000, 1'b1, 2'b00},
         {3'b001, 1'b0, 3'b000, 1'b1, 2'b00},
         {3'b001, 1'b1, 3'b000, 1'b1, 2'b00},
         {3'b001, 1'b0, 3'b001, 1'b1, 2'b01},
         {3'b000, 1'b0, 3'b000, 1'b0, 2'b01},
         {3'b010, 1'b0, 3'b010, 1'b1, 2'b01},
         {3'b000, 1'b0, 3'b000, 1'b0, 2'b01}
      };
      req_a = 3'b001;
      len_a = {4'd0, 4'd0, 4'd2};
      for (int c = 0; c < 8; c++) begin
         tick();
         checks++;
         if (obs_a() !== tv[c]) begin
            failures++;
            $display("FAIL ignore c=%0d got=%b exp=%b", c + 1, obs_a(), tv[c]);
         end
         if (c == 0) begin
            req_a = 3'b011;
            len_a = {4'd0, 4'd0, 4'd7};
         end
         if (c == 4) req_a = 3'b010;
         if (c == 6) req_a = '0;
      end
   endtask

   task automatic test_gap0();
      logic [9:0] e;
      logic       es;
      int         nst;
      nst   = 0;
      req_b = 3'b001;
      len_b = {4'd0, 4'd0, 4'd4};
      for (int c = 1; c <= 6; c++) begin
         tick();
         es = (c <= 4);
         e  = {(c <= 5) ? 3'b001 : 3'b000, es,
               (c == 5) ? 3'b001 : 3'b000, (c <= 5), 2'(nst % 3)};
         checks++;
         if (obs_b() !== e) begin
            failures++;
            $display("FAIL gap0 c=%0d got=%b exp=%b", c, obs_b(), e);
         end
         if (es) nst++;
         if (c == 5) req_b = '0;
      end
   endtask

   task automatic test_async_reset();
      logic [9:0] e;
      do_reset();
      req_a = 3'b001;
      len_a = {4'd0, 4'd0, 4'd3};
      repeat (4) tick();
      e = {3'b001, 1'b1, 3'b000, 1'b1, 2'b01};
      checks++;
      if (obs_a() !== e) begin
         failures++;
         $display("FAIL arst_pre got=%b exp=%b", obs_a(), e);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (obs_a() !== 10'b0) begin
         failures++;
         $display("FAIL arst_now got=%b exp=%b", obs_a(), 10'b0);
      end
      req_a = 3'b011;
      len_a = {4'd0, 4'd1, 4'd1};
      #2;
      rst = 1'b1;
      tick();
      e = {3'b001, 1'b1, 3'b000, 1'b1, 2'b00};
      checks++;
      if (obs_a() !== e) begin
         failures++;
         $display("FAIL arst_regrant got=%b exp=%b", obs_a(), e);
      end
      tick();
      e = {3'b001, 1'b0, 3'b001, 1'b1, 2'b01};
      checks++;
      if (obs_a() !== e) begin
         failures++;
         $display("FAIL arst_done got=%b exp=%b", obs_a(), e);
      end
      req_a = '0;
      tick();
   endtask

   initial begin
      rst   = 1'b0;
      req_a = '0;
      req_b = '0;
      len_a = '0;
      len_b = '0;
      test_reset();
      test_single();
      test_rr();
      test_zero_len();
      test_abort();
      test_ignore();
      test_gap0();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
